// File: rtl/bcd_xs3_pkg.sv
// Shared definitions for the serial XS3 link (transmitter and receiver).
package bcd_xs3_pkg;

  localparam int                   DATA_BITS  = 4;
  localparam logic [DATA_BITS-1:0] XS3_OFFSET = 4'd3;
  localparam logic [DATA_BITS-1:0] BCD_MAX    = 4'd9;

  typedef enum logic {
    IDLE,
    SHIFT
  } frame_state_e;

  // Returns the code rearranged so that bit 0 is the first bit on the line.
  function automatic logic [DATA_BITS-1:0] line_order(
    input logic [DATA_BITS-1:0] code,
    input logic                 msb_first
  );
    return msb_first ? {code[0], code[1], code[2], code[3]} : code;
  endfunction

endpackage

// File: rtl/bcd_xs3_tx_if.sv
// Digit handshake and serial line of the XS3 transmitter.
interface bcd_xs3_tx_if;
  import bcd_xs3_pkg::*;

  logic [DATA_BITS-1:0] bcd_in;
  logic                 in_valid;
  logic                 in_ready;
  logic                 y;
  logic                 sof;
  logic                 busy;
  logic                 err;

  modport master (
    output bcd_in, in_valid,
    input  in_ready, y, sof, busy, err
  );

  modport slave (
    input  bcd_in, in_valid,
    output in_ready, y, sof, busy, err
  );

endinterface

// File: rtl/bcd_to_xs3.sv
// Combinational BCD digit to excess-3 code, with a legality flag for 0-9.
module bcd_to_xs3
  import bcd_xs3_pkg::*;
(
  input  logic [DATA_BITS-1:0] i_bcd,
  output logic                 o_legal,
  output logic [DATA_BITS-1:0] o_xs3
);

  assign o_legal = (i_bcd <= BCD_MAX);
  assign o_xs3   = i_bcd + XS3_OFFSET;

endmodule

// File: rtl/bcd_xs3_tx.sv
// Serial excess-3 transmitter: BCD digits in over valid/ready, XS3 frames out one bit per clock.
// Define BCD_XS3_TX_PARITY_EN to append an even-parity bit, always last, to every frame.
//
// state | meaning
// IDLE  | line parked at IDLE_BIT, nothing in flight
// SHIFT | frame on y; r_cnt counts remaining bits down to 0 (last bit)
module bcd_xs3_tx
  import bcd_xs3_pkg::*;
#(
  parameter logic MSB_FIRST = 1'b0,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  bcd_xs3_tx_if.slave  bus
);

`ifdef BCD_XS3_TX_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 1;
`else
  localparam int FRAME_BITS = DATA_BITS;
`endif
  localparam logic [2:0] CNT_LOAD = 3'(FRAME_BITS - 1);

  frame_state_e            r_state;
  logic [2:0]              r_cnt;
  logic [FRAME_BITS-2:0]   r_shift;
  logic [FRAME_BITS-1:0]   r_hold;
  logic                    r_hold_full;
  logic                    r_y;
  logic                    r_sof;
  logic                    r_busy;
  logic                    r_err;

  logic                    w_legal;
  logic [DATA_BITS-1:0]    w_xs3;
  logic [DATA_BITS-1:0]    w_order;
  logic [FRAME_BITS-1:0]   w_frame;
  logic                    w_accept;
  logic                    w_take;
  logic                    w_load;
  logic                    w_unload;
  logic                    w_step;
  logic                    w_stash;
  logic                    w_to_idle;
  logic [FRAME_BITS-1:0]   w_load_frame;

  bcd_to_xs3 u_conv (
    .i_bcd   (bus.bcd_in),
    .o_legal (w_legal),
    .o_xs3   (w_xs3)
  );

  assign w_order = line_order(w_xs3, MSB_FIRST);
`ifdef BCD_XS3_TX_PARITY_EN
  assign w_frame = {^w_xs3, w_order};
`else
  assign w_frame = w_order;
`endif

  assign w_accept = bus.in_valid && !r_hold_full;
  assign w_take   = w_accept && w_legal;

  always_comb begin
    w_load       = 1'b0;
    w_unload     = 1'b0;
    w_step       = 1'b0;
    w_stash      = 1'b0;
    w_to_idle    = 1'b0;
    w_load_frame = w_frame;
    case (r_state)
      IDLE: w_load = w_take;
      SHIFT: begin
        if (r_cnt == 3'd0) begin
          // Last bit: the next frame follows with no gap, holding register first.
          if (r_hold_full) begin
            w_load       = 1'b1;
            w_unload     = 1'b1;
            w_load_frame = r_hold;
          end else if (w_take) begin
            w_load = 1'b1;
          end else begin
            w_to_idle = 1'b1;
          end
        end else begin
          w_step  = 1'b1;
          w_stash = w_take;
        end
      end
      default: w_to_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 3'd0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_y         <= IDLE_BIT;
      r_sof       <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_sof <= 1'b0;
      r_err <= w_accept && !w_legal;
      if (w_load) begin
        r_state <= SHIFT;
        r_y     <= w_load_frame[0];
        r_shift <= w_load_frame[FRAME_BITS-1:1];
        r_cnt   <= CNT_LOAD;
        r_sof   <= 1'b1;
        r_busy  <= 1'b1;
      end else if (w_step) begin
        r_cnt   <= r_cnt - 3'd1;
        r_y     <= r_shift[0];
        r_shift <= r_shift >> 1;
      end else if (w_to_idle) begin
        r_state <= IDLE;
        r_y     <= IDLE_BIT;
        r_busy  <= 1'b0;
      end
      if (w_stash) begin
        r_hold      <= w_frame;
        r_hold_full <= 1'b1;
      end else if (w_unload) begin
        r_hold_full <= 1'b0;
      end
    end
  end

  assign bus.in_ready = !r_hold_full;
  assign bus.y        = r_y;
  assign bus.sof      = r_sof;
  assign bus.busy     = r_busy;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_bcd_xs3_tx.sv
// Scoreboard bench for bcd_xs3_tx: expected line bits queued on accept, checked as the line shifts.
module tb_bcd_xs3_tx;

  localparam logic TB_MSB  = 1'b0;
  localparam logic TB_IDLE = 1'b0;
`ifdef BCD_XS3_TX_PARITY_EN
  localparam int FB = 5;
`else
  localparam int FB = 4;
`endif

  typedef struct {
    logic b;
    logic first;
  } exp_t;

  logic clk;
  logic rst_n;
  bcd_xs3_tx_if bus ();

  bcd_xs3_tx #(
    .MSB_FIRST (TB_MSB),
    .IDLE_BIT  (TB_IDLE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   err_cyc  = -1;
  int   run_len  = 0;
  int   last_run = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Line monitor: pops one expected bit per busy cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0;
    end else begin
      if (bus.busy) begin
        run_len++;
        if (sb.size() == 0) begin
          chk("unexpected_bit", 32'(bus.y), 32'hFFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("y_bit", 32'(bus.y), 32'(e.b));
          chk("sof", 32'(bus.sof), 32'(e.first));
        end
      end else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
        chk("idle_y", 32'(bus.y), 32'(TB_IDLE));
        chk("idle_sof", 32'(bus.sof), 32'd0);
      end
      chk("err", 32'(bus.err), 32'(cyc == err_cyc));
    end
  end

  task automatic push_frame(input int d);
    int x;
    int ones;
    x = (d + 3) & 15;
    ones = 0;
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      int idx;
      idx = TB_MSB ? (3 - i) : i;
      e.b = 1'((x >> idx) & 1);
      e.first = (i == 0);
      ones += (x >> i) & 1;
      sb.push_back(e);
    end
    if (FB == 5) begin
      exp_t p;
      p.b = 1'(ones % 2);
      p.first = 1'b0;
      sb.push_back(p);
    end
  endtask

  // Called at a negedge; returns at the negedge after the digit is accepted.
  task automatic send(input int d);
    int n;
    bus.bcd_in   = 4'(d);
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("send_timeout", 32'd1, 32'd0);
      bus.in_valid = 1'b0;
      return;
    end
    if (d <= 9) push_frame(d);
    else err_cyc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic drop();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((bus.busy || sb.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy || sb.size() != 0) chk("idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.bcd_in   = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_y", 32'(bus.y), 32'(TB_IDLE));
    chk("rst_sof", 32'(bus.sof), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame, digit 5
    send(5); drop();
    wait_idle();
    chk("run_d5", 32'(last_run), 32'(FB));

    // Extremes of the legal range
    send(0); drop(); wait_idle();
    chk("run_d0", 32'(last_run), 32'(FB));
    send(9); drop(); wait_idle();
    chk("run_d9", 32'(last_run), 32'(FB));

    // Back-to-back 3 then 7 through the holding register
    send(3); send(7); drop();
    chk("ready_hold_full", 32'(bus.in_ready), 32'd0);
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_low_cycles", 32'(n), 32'(FB - 1));
    wait_idle();
    chk("run_b2b", 32'(last_run), 32'(2 * FB));

    // Digit arriving exactly on the last-bit cycle goes straight to the shifter
    send(6); drop();
    repeat (FB - 1) @(negedge clk);
    chk("last_cycle_ready", 32'(bus.in_ready), 32'd1);
    send(2); drop();
    wait_idle();
    chk("run_direct", 32'(last_run), 32'(2 * FB));

    // Continuous stream of all digits
    for (int d = 0; d < 10; d++) send(d);
    drop();
    wait_idle();
    chk("run_stream", 32'(last_run), 32'(10 * FB));

    // Illegal digit then a legal one
    send(12); drop();
    repeat (3) @(negedge clk);
    chk("illegal_busy", 32'(bus.busy), 32'd0);
    chk("illegal_ready", 32'(bus.in_ready), 32'd1);
    send(4); drop();
    wait_idle();
    chk("run_after_err", 32'(last_run), 32'(FB));

    // Reset during bit 2 with the holding register full
    send(8); send(1); drop();
    chk("pre_rst_hold", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("arst_y", 32'(bus.y), 32'(TB_IDLE));
    chk("arst_sof", 32'(bus.sof), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_err", 32'(bus.err), 32'd0);
    chk("arst_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

    send(7); drop();
    wait_idle();
    chk("run_post_rst", 32'(last_run), 32'(FB));
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
